// File: rtl/inst_rom.sv
// Instruction memory responder: word array with registered read and a LATENCY-deep response pipeline.
// Optional macro INST_ROM_RANGE_CHECK_EN flags fetches with nonzero upper address bits as out-of-range.
module inst_rom #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    input  logic                  stall,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic [31:0]           inst,
    output logic [31:0]           inst_addr,
    output logic                  inst_valid,
    output logic                  misalign,
    output logic                  oob
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic        valid;
        logic        misalign;
        logic        oob;
        logic [31:0] addr;
        logic [31:0] inst;
    } resp_t;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_data_q;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  accept;
    logic                  upper_nz;
    logic                  rd_en;

    assign fetch_idx = addr[DEPTH_LOG2+1:2];
    assign accept    = ce & ~stall;

`ifdef INST_ROM_RANGE_CHECK_EN
    assign upper_nz = |addr[31:DEPTH_LOG2+2];
`else
    assign upper_nz = 1'b0;
`endif

    // Out-of-range fetches never touch the array.
    assign rd_en = accept & ~upper_nz;

    // Non-blocking read alongside the write gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[fetch_idx];
        end
    end

    logic        s0_valid_q, s0_valid_d;
    logic        s0_misalign_q, s0_misalign_d;
    logic        s0_oob_q, s0_oob_d;
    logic [31:0] s0_addr_q, s0_addr_d;

    always_comb begin
        s0_valid_d    = s0_valid_q;
        s0_misalign_d = s0_misalign_q;
        s0_oob_d      = s0_oob_q;
        s0_addr_d     = s0_addr_q;
        if (!stall) begin
            s0_valid_d    = ce;
            s0_misalign_d = ce & (addr[1:0] != 2'b00);
            s0_oob_d      = ce & upper_nz;
            s0_addr_d     = ce ? addr : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid_q    <= 1'b0;
            s0_misalign_q <= 1'b0;
            s0_oob_q      <= 1'b0;
            s0_addr_q     <= 32'h0;
        end else begin
            s0_valid_q    <= s0_valid_d;
            s0_misalign_q <= s0_misalign_d;
            s0_oob_q      <= s0_oob_d;
            s0_addr_q     <= s0_addr_d;
        end
    end

    resp_t s0_resp;
    resp_t pipe [LATENCY];

    // The raw array word is only exposed for a clean, valid, in-range fetch.
    always_comb begin
        s0_resp          = '0;
        s0_resp.valid    = s0_valid_q;
        s0_resp.misalign = s0_misalign_q;
        s0_resp.oob      = s0_oob_q;
        s0_resp.addr     = s0_addr_q;
        s0_resp.inst     = (s0_valid_q && !s0_misalign_q && !s0_oob_q) ? rd_data_q : 32'h0;
    end

    assign pipe[0] = s0_resp;

    genvar gi;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_stage
            resp_t stage_q;
            resp_t stage_d;

            always_comb begin
                stage_d = stall ? stage_q : pipe[gi-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign pipe[gi] = stage_q;
        end
    endgenerate

    assign inst       = pipe[LATENCY-1].inst;
    assign inst_addr  = pipe[LATENCY-1].addr;
    assign inst_valid = pipe[LATENCY-1].valid;
    assign misalign   = pipe[LATENCY-1].misalign;
    assign oob        = pipe[LATENCY-1].oob;

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a delay-line model on non-stalled edges.
module tb_inst_rom;

    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic        valid;
        logic        misalign;
        logic        oob;
        logic [31:0] addr;
        logic [31:0] inst;
    } resp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ce;
    logic [31:0]           addr;
    logic                  stall;
    logic                  load_we;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [31:0]           load_data;
    logic [31:0]           inst;
    logic [31:0]           inst_addr;
    logic                  inst_valid;
    logic                  misalign;
    logic                  oob;

    int compared   = 0;
    int mismatched = 0;

    inst_rom #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .stall      (stall),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .inst_valid (inst_valid),
        .misalign   (misalign),
        .oob        (oob)
    );

    always #5 clk = ~clk;

    // Reference: array contents plus the list of responses produced on non-stalled edges;
    // the visible response is the one produced LATENCY-1 such edges ago.
    logic [31:0] mem_m [DEPTH];
    resp_t       hist_q [$];
    resp_t       ent;
    resp_t       exp_r;

    always begin
        @(posedge clk);
        if (!rst) begin
            hist_q.delete();
        end else if (!stall) begin
            ent = '0;
            if (ce) begin
                ent.valid    = 1'b1;
                ent.addr     = addr;
                ent.misalign = (addr % 4) != 0;
`ifdef INST_ROM_RANGE_CHECK_EN
                ent.oob      = (addr >> (DEPTH_LOG2 + 2)) != 0;
`else
                ent.oob      = 1'b0;
`endif
                ent.inst     = (ent.misalign || ent.oob) ? 32'h0 : mem_m[(addr >> 2) % DEPTH];
            end
            hist_q.push_back(ent);
            if (hist_q.size() > LATENCY) void'(hist_q.pop_front());
        end
        if (load_we) mem_m[load_addr] = load_data;
        #1;
        exp_r = (hist_q.size() == LATENCY) ? hist_q[0] : '0;
        compared++;
        if (inst !== exp_r.inst || inst_addr !== exp_r.addr || inst_valid !== exp_r.valid ||
            misalign !== exp_r.misalign || oob !== exp_r.oob) begin
            mismatched++;
            $display("FAIL model t=%0t got v=%b i=%h a=%h m=%b o=%b exp v=%b i=%h a=%h m=%b o=%b",
                     $time, inst_valid, inst, inst_addr, misalign, oob,
                     exp_r.valid, exp_r.inst, exp_r.addr, exp_r.misalign, exp_r.oob);
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("chk %s = %h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_resp(input string name, input logic v, input logic [31:0] i,
                              input logic [31:0] a, input logic m, input logic o);
        check_lit({name, ".valid"}, {31'h0, inst_valid}, {31'h0, v});
        check_lit({name, ".inst"}, inst, i);
        check_lit({name, ".addr"}, inst_addr, a);
        check_lit({name, ".mis"}, {31'h0, misalign}, {31'h0, m});
        check_lit({name, ".oob"}, {31'h0, oob}, {31'h0, o});
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; addr = 32'h0; stall = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = 32'h0;
        repeat (3) tick();
        check_resp("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;

        // Fill the whole array so every fetch has a defined word.
        for (int i = 0; i < DEPTH; i++) begin
            load_we = 1'b1; load_addr = i[DEPTH_LOG2-1:0];
            case (i)
                0: load_data = 32'h11;
                1: load_data = 32'h22;
                2: load_data = 32'h33;
                3: load_data = 32'h44;
                5: load_data = 32'hBEEF;
                default: load_data = $urandom;
            endcase
            tick();
        end
        load_we = 1'b0;

        // Back-to-back fetches with a stall while 0x22 is presented.
        ce = 1'b1; addr = 32'h0;  tick();
        addr = 32'h4;             tick(); check_resp("b2b0", 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        addr = 32'h8;             tick(); check_resp("b2b1", 1'b1, 32'h22, 32'h4, 1'b0, 1'b0);
        addr = 32'hC; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_resp("stall", 1'b1, 32'h22, 32'h4, 1'b0, 1'b0);
        end
        stall = 1'b0;             tick(); check_resp("b2b2", 1'b1, 32'h33, 32'h8, 1'b0, 1'b0);
        ce = 1'b0;                tick(); check_resp("b2b3", 1'b1, 32'h44, 32'hC, 1'b0, 1'b0);

        // Bubble then misaligned fetch.
        ce = 1'b1; addr = 32'h0;  tick(); check_resp("bub0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ce = 1'b0;                tick(); check_resp("bub1", 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        ce = 1'b1; addr = 32'h6;  tick(); check_resp("bub2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ce = 1'b0;                tick(); check_resp("mis", 1'b1, 32'h0, 32'h6, 1'b1, 1'b0);

        // Load and fetch to the same word on the same edge.
        ce = 1'b1; addr = 32'h14; load_we = 1'b1; load_addr = 5; load_data = 32'hDEAD; tick();
        load_we = 1'b0;           tick(); check_resp("coll_old", 1'b1, 32'hBEEF, 32'h14, 1'b0, 1'b0);
        ce = 1'b0;                tick(); check_resp("coll_new", 1'b1, 32'hDEAD, 32'h14, 1'b0, 1'b0);

        // Address beyond the array.
        ce = 1'b1; addr = 32'h1000; tick();
        ce = 1'b0;                tick();
`ifdef INST_ROM_RANGE_CHECK_EN
        check_resp("range", 1'b1, 32'h0, 32'h1000, 1'b0, 1'b1);
`else
        check_resp("range", 1'b1, 32'h11, 32'h1000, 1'b0, 1'b0);
`endif

        // Asynchronous reset with two requests in flight.
        ce = 1'b1; addr = 32'h0;  tick();
        addr = 32'h4;             tick();
        rst = 1'b0; #1;
        check_resp("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1; ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); check_resp("post_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        // Randomized traffic checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            int kind;
            logic [DEPTH_LOG2-1:0] widx;
            rst       = ($urandom_range(0, 299) != 0);
            ce        = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            load_we   = ($urandom_range(0, 3) == 0);
            widx      = DEPTH_LOG2'($urandom_range(0, 15));
            load_addr = ($urandom_range(0, 1) == 0) ? widx : DEPTH_LOG2'($urandom);
            load_data = $urandom;
            kind      = $urandom_range(0, 9);
            case (kind)
                7:       addr = {20'h0, DEPTH_LOG2'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                8:       addr = {20'($urandom_range(1, 20'hFFFFF)), DEPTH_LOG2'($urandom_range(0, 15)), 2'b00};
                9:       addr = $urandom;
                default: addr = {20'h0, DEPTH_LOG2'($urandom_range(0, 15)), 2'b00};
            endcase
            tick();
        end
        rst = 1'b1; ce = 1'b0; stall = 1'b0; load_we = 1'b0;
        repeat (LATENCY + 1) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
